// File: rtl/lfsr_pkg.sv
// Shared types and defaults for the LFSR block scheduler and its one-step lfsr stage.
package lfsr_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int POLY_DEF  = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Galois right-shift feedback masks for maximal-length polynomials.
  function automatic logic [63:0] taps_for(input int w);
    case (w)
      8:       taps_for = 64'hB8;
      16:      taps_for = 64'hB400;
      24:      taps_for = 64'hD8_0000;
      32:      taps_for = 64'h8020_0003;
      64:      taps_for = 64'hD800_0000_0000_0000;
      default: taps_for = (64'd1 << (w - 1)) | 64'd1;
    endcase
  endfunction

endpackage

// File: rtl/lfsr.sv
// One combinational Galois LFSR step: shift right, fold feedback taps in when bit 0 was set.
module lfsr
  import lfsr_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] state,
  output logic [WIDTH-1:0] next_state
);

  localparam logic [63:0]      TAPS_ALL = taps_for(WIDTH);
  localparam logic [WIDTH-1:0] TAPS     = TAPS_ALL[WIDTH-1:0];

  assign next_state = (state >> 1) ^ (state[0] ? TAPS : '0);

endmodule

// File: rtl/lfsr_sched.sv
// Emits `count` blocks of POLY consecutive LFSR states with valid/ready handshake.
// Optional LFSR_SCHED_LOCKUP_EN: zero seed is replaced by all ones and flagged on lockup_err.
//
// state   | meaning
// IDLE    | waiting for start
// RUN     | presenting blocks, advancing POLY steps per transfer
// DONE    | one-cycle done pulse, then back to IDLE
module lfsr_sched
  import lfsr_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int POLY  = POLY_DEF,
  parameter int CNTW  = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      seed,
  input  logic [CNTW-1:0]       count,
  input  logic                  abort,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [POLY*WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done,
  output logic                  lockup_err
);

  state_t           state;
  logic [WIDTH-1:0] s;
  logic [CNTW-1:0]  blocks_left;
  logic [WIDTH-1:0] lane [POLY+1];
  logic [WIDTH-1:0] seed_load;
  logic             xfer;
  logic             last_blk;

  assign lane[0] = s;

  for (genvar g = 0; g < POLY; g++) begin : g_chain
    lfsr #(.WIDTH(WIDTH)) u_step (
      .state      (lane[g]),
      .next_state (lane[g+1])
    );
    assign out_data[g*WIDTH +: WIDTH] = lane[g];
  end

  assign last_blk = (blocks_left == CNTW'(1));
  assign xfer     = out_valid && out_ready;
  assign out_last = out_valid && last_blk;

`ifdef LFSR_SCHED_LOCKUP_EN
  logic seed_zero;
  assign seed_zero = (seed == '0);
  assign seed_load = seed_zero ? '1 : seed;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lockup_err <= 1'b0;
    end else if (state == ST_IDLE && start && seed_zero) begin
      lockup_err <= 1'b1;
    end
  end
`else
  assign seed_load  = seed;
  assign lockup_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      s           <= '1;
      blocks_left <= '0;
      out_valid   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            s           <= seed_load;
            blocks_left <= count;
            busy        <= 1'b1;
            if (count != '0) begin
              state     <= ST_RUN;
              out_valid <= 1'b1;
            end else begin
              state <= ST_DONE;
              done  <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (xfer) begin
            s <= lane[POLY];
            if (blocks_left != '0) blocks_left <= blocks_left - CNTW'(1);
          end
          // abort wins over further blocks, but a same-cycle transfer is still consumed
          if ((xfer && last_blk) || abort) begin
            state     <= ST_DONE;
            out_valid <= 1'b0;
            done      <= 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state     <= ST_IDLE;
          out_valid <= 1'b0;
          done      <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lfsr_sched.sv
// Randomized self-checking bench for lfsr_sched against a step-by-step LFSR reference.
module tb_lfsr_sched;

  localparam int W = 16;
  localparam int P = 8;
  localparam int C = 16;

  logic           clk = 1'b0;
  logic           reset_n;
  logic           start;
  logic [W-1:0]   seed;
  logic [C-1:0]   count;
  logic           abort;
  logic           out_ready;
  logic           out_valid;
  logic [P*W-1:0] out_data;
  logic           out_last;
  logic           busy;
  logic           done;
  logic           lockup_err;

  int vectors = 0;
  int errors  = 0;
  logic exp_lock = 1'b0;

  lfsr_sched #(.WIDTH(W), .POLY(P), .CNTW(C)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .seed       (seed),
    .count      (count),
    .abort      (abort),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_last   (out_last),
    .busy       (busy),
    .done       (done),
    .lockup_err (lockup_err)
  );

  always #5 clk = ~clk;

  // Reference: advance a 16-bit Galois LFSR (x^16+x^14+x^13+x^11+1) by n steps.
  function automatic logic [W-1:0] adv(input logic [W-1:0] x, input int n);
    logic [W-1:0] v = x;
    for (int k = 0; k < n; k++) v = v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one run and checks every cycle against the reference.
  task automatic run_case(input logic [W-1:0] sd, input int cnt, input int stall_first,
                          input int stall_pct, input int abort_xfer, input bit poke_start,
                          output int xfers);
    logic [W-1:0] cur;
    int remaining, cyc;
    bit rdy, ab;
    xfers = 0;
    start = 1'b1; seed = sd; count = C'(cnt); abort = 1'b0; out_ready = 1'b0;
    tick();
    start = 1'b0;
    cur = sd;
`ifdef LFSR_SCHED_LOCKUP_EN
    if (sd == '0) begin cur = '1; exp_lock = 1'b1; end
`endif
    remaining = cnt;
    cyc = 0;
    if (cnt != 0) begin
      while (1) begin
        vectors++;
        if (out_valid !== 1'b1 || done !== 1'b0 || busy !== 1'b1) begin
          errors++;
          $display("FAIL run_flags cyc=%0d valid=%b done=%b busy=%b, required 1/0/1", cyc, out_valid, done, busy);
        end
        for (int i = 0; i < P; i++) begin
          vectors++;
          if (out_data[i*W +: W] !== adv(cur, i)) begin
            errors++;
            $display("FAIL lane%0d cyc=%0d got=%h required=%h", i, cyc, out_data[i*W +: W], adv(cur, i));
          end
        end
        vectors++;
        if (out_last !== (remaining == 1) || lockup_err !== exp_lock) begin
          errors++;
          $display("FAIL last_lock cyc=%0d last=%b lock=%b, required %b/%b", cyc, out_last, lockup_err, remaining == 1, exp_lock);
        end
        rdy = (cyc >= stall_first) && ($urandom_range(0, 99) >= stall_pct);
        ab  = (abort_xfer > 0) && rdy && (xfers + 1 == abort_xfer);
        out_ready = rdy;
        abort = ab;
        start = poke_start && $urandom_range(0, 1);
        seed  = W'($urandom);
        count = C'($urandom);
        tick();
        out_ready = 1'b0; abort = 1'b0; start = 1'b0;
        cyc++;
        if (rdy) begin
          cur = adv(cur, P);
          remaining--;
          xfers++;
        end
        if ((rdy && remaining == 0) || ab) break;
        if (cyc > 2000) begin
          errors++;
          $display("FAIL run_timeout no end after %0d cycles", cyc);
          break;
        end
      end
    end
    vectors++;
    if (out_valid !== 1'b0 || done !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL done_pulse valid=%b done=%b busy=%b, required 0/1/1", out_valid, done, busy);
    end
    start = 1'b1;  // must be ignored in DONE
    tick();
    start = 1'b0;
    vectors++;
    if (out_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL back_idle valid=%b done=%b busy=%b, required 0/0/0", out_valid, done, busy);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; seed = '0; count = '0; abort = 1'b0; out_ready = 1'b0;
    #12;
    vectors++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || lockup_err !== 1'b0 ||
        out_last !== 1'b0 || out_data[W-1:0] !== 16'hFFFF) begin
      errors++;
      $display("FAIL reset_state valid=%b busy=%b done=%b lock=%b last=%b lane0=%h, required 0/0/0/0/0/ffff",
               out_valid, busy, done, lockup_err, out_last, out_data[W-1:0]);
    end
    @(negedge clk);
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int n;
    run_case(16'hFFFF, 3, 0, 0, 0, 1'b0, n);
    vectors++;
    if (n !== 3) begin errors++; $display("FAIL basic_xfers got=%0d required=3", n); end
  endtask

  task automatic test_stall();
    int n;
    run_case(16'h1234, 2, 4, 0, 0, 1'b0, n);
    vectors++;
    if (n !== 2) begin errors++; $display("FAIL stall_xfers got=%0d required=2", n); end
  endtask

  task automatic test_zero_count();
    int n;
    run_case(16'hBEEF, 0, 0, 0, 0, 1'b0, n);
    vectors++;
    if (n !== 0) begin errors++; $display("FAIL zero_count_xfers got=%0d required=0", n); end
  endtask

  task automatic test_abort();
    int n;
    run_case(16'hACE1, 100, 0, 20, 5, 1'b1, n);
    vectors++;
    if (n !== 5) begin errors++; $display("FAIL abort_xfers got=%0d required=5", n); end
    run_case(16'h0F0F, 65535, 0, 0, 3, 1'b1, n);
    vectors++;
    if (n !== 3) begin errors++; $display("FAIL maxcount_abort_xfers got=%0d required=3", n); end
  endtask

  task automatic test_zero_seed();
    int n;
    run_case(16'h0000, 2, 0, 0, 0, 1'b0, n);
    vectors++;
    if (lockup_err !== exp_lock) begin
      errors++;
      $display("FAIL zero_seed_lock got=%b required=%b", lockup_err, exp_lock);
    end
  endtask

  task automatic test_back_to_back();
    int n, c;
    for (int r = 0; r < 6; r++) begin
      c = $urandom_range(1, 12);
      run_case(W'($urandom_range(1, 65535)), c, $urandom_range(0, 2), 30, 0, 1'b1, n);
      vectors++;
      if (n !== c) begin errors++; $display("FAIL b2b_xfers run=%0d got=%0d required=%0d", r, n, c); end
    end
  endtask

  task automatic test_reset_midrun();
    start = 1'b1; seed = 16'h5A5A; count = C'(50); out_ready = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    #2;
    reset_n = 1'b0;
    exp_lock = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || out_data[W-1:0] !== 16'hFFFF) begin
      errors++;
      $display("FAIL midrun_reset valid=%b busy=%b done=%b lane0=%h, required 0/0/0/ffff",
               out_valid, busy, done, out_data[W-1:0]);
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      vectors++;
      if (done !== 1'b0 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL post_reset_quiet k=%0d done=%b valid=%b, required 0/0", k, done, out_valid);
      end
    end
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_zero_count();
    test_abort();
    test_zero_seed();
    test_back_to_back();
    test_reset_midrun();
    test_basic();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/lfsr_sched.md
LFSR_SCHED -- requirements
Module: lfsr_sched

Interface
REQ-001 SHALL have parameter WIDTH, default 16: LFSR state/word width in bits.
REQ-002 SHALL have parameter POLY, default 8: number of chained one-step lfsr stages, i.e. lanes per output block.
REQ-003 SHALL have parameter CNTW, default 16: width of the block counter.
REQ-004 clk  input  1  single clock, all state updates on its rising edge.
REQ-005 reset_n  input  1  reset, asynchronous and active-low.
REQ-006 start  input  1  begin a run; sampled in IDLE only.
REQ-007 seed  input  WIDTH  initial LFSR state, captured on accepted start.
REQ-008 count  input  CNTW  number of blocks to emit, captured on accepted start.
REQ-009 abort  input  1  terminate the current run.
REQ-010 out_ready  input  1  consumer accepts the current block.
REQ-011 out_valid  output  1  out_data holds a valid block.
REQ-012 out_data  output  POLY*WIDTH  lane i (bits i*WIDTH+:WIDTH) is the state advanced i steps.
REQ-013 out_last  output  1  current block is the final one of the run.
REQ-014 busy  output  1  state is not IDLE.
REQ-015 done  output  1  one-cycle pulse at end of run.
REQ-016 lockup_err  output  1  sticky zero-state flag (see Configuration).

Function
REQ-017 SHALL implement FSM states IDLE, RUN, DONE.
REQ-018 IDLE and start=1: capture seed into state register s, count into blocks_left; go to RUN if count!=0, else go to DONE.
REQ-019 out_valid SHALL be 1 exactly when state is RUN; first valid block appears the cycle after start is accepted.
REQ-020 Transfer = out_valid && out_ready; on transfer, s <= s advanced POLY steps and blocks_left decrements.
REQ-021 out_data, out_last SHALL stay stable while out_valid && !out_ready.
REQ-022 out_last = (blocks_left==1) in RUN.
REQ-023 A transfer with out_last=1 SHALL move to DONE.
REQ-024 abort in RUN SHALL move to DONE; a transfer in the same cycle still counts and advances s.
REQ-025 DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-026 start outside IDLE and abort outside RUN SHALL be ignored.
REQ-027 blocks_left SHALL never underflow; a count of 2^CNTW-1 SHALL be supported.

Reset
REQ-028 reset_n=0 SHALL immediately force IDLE, s=all ones, blocks_left=0, out_valid=0, done=0, lockup_err=0, independent of clk, including mid-run.

Configuration
REQ-029 Macro LFSR_SCHED_LOCKUP_EN defined: a zero seed SHALL be replaced by all ones at capture, lockup_err set and held until reset.
REQ-030 Macro undefined: seed loaded unchanged (zero state repeats zero); lockup_err tied 0.

Structure
REQ-031 Shared package lfsr_pkg SHALL hold the FSM state enum and the default WIDTH/POLY constants.
REQ-032 SHALL instantiate POLY copies of existing sub-module lfsr (one-step combinational) in a chain from s; no other sub-modules.

Verification
REQ-033 seed=16'hFFFF, count=3, out_ready=1 -> out_valid for 3 consecutive cycles, lane0 of block0=16'hFFFF, each block lane0 equals golden 8-step advance of the previous, out_last on 3rd block, done one cycle later.
REQ-034 count=2, out_ready low 4 cycles then high -> out_data frozen while stalled, exactly 2 transfers, done once.
REQ-035 count=0 -> no out_valid, done pulse 1 cycle after start, back to IDLE.
REQ-036 count=100, abort asserted on 5th transfer cycle -> 5 blocks accepted, done next cycle, start during RUN ignored.
REQ-037 seed=16'h0000 -> with LFSR_SCHED_LOCKUP_EN lane0=16'hFFFF and lockup_err=1; without, all lanes 0 and lockup_err=0.
REQ-038 reset_n dropped mid-run between clock edges -> out_valid and busy go 0 immediately, no done pulse.
